cd_sram_write_coalescer: RTL
============================

// Module: cd_sram_write_coalescer
// PURPOSE
//  Sits between the rasterizer's Color/Depth write port and the Color/Depth SRAM.
//  Merges consecutive masked 16-pixel writes to the same SRAM word in a holding register.
//  Buffers evicted words in a FIFO and drains them whenever the SRAM grants a write slot.
//  Flags read-after-write hazards so depth_org is never fetched from a stale SRAM word.
// PARAMETERS
//  FIFO_DEPTH    4   entries in the eviction FIFO; power of two, >=2
//  HOLD_TIMEOUT  8   idle cycles before the holding register is evicted; >=1
// PORTS
//  clk          in   1    clock
//  srst_n       in   1    reset, asynchronous, active-low
//  wr_valid     in   1    rasterizer write request
//  wr_ready     out  1    write accepted when wr_valid && wr_ready
//  wr_addr      in   16   SRAM word address, 16 pixels per word
//  wr_color     in   384  16 lanes x 24-bit RGB; lane i = bits [24i+23:24i]
//  wr_depth     in   336  16 lanes x 21-bit depth; lane i = bits [21i+20:21i]
//  wr_mask      in   16   bit i=1: lane i is written
//  rd_addr      in   16   address the rasterizer is about to read depth from
//  rd_hazard    out  1    combinational: rd_addr has pending or in-flight data
//  sram_gnt     in   1    SRAM write slot available this cycle
//  sram_we      out  1    SRAM write strobe
//  sram_addr    out  16   SRAM write address
//  sram_color   out  384  SRAM write colour data
//  sram_depth   out  336  SRAM write depth data
//  sram_mask    out  16   SRAM lane mask, bit i=1: write lane i
//  flush        in   1    one-cycle pulse: drain all pending data (end of frame)
//  flush_done   out  1    one-cycle pulse: flush complete
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, hold invalid, timer 0, FSM=RUN. Pending data is discarded.
//  FSM states:
//   RUN:   normal operation; flush -> FLUSH.
//   FLUSH: wr_ready=0; evict hold when the FIFO is not full; wait until idle.
//          Idle = hold invalid, FIFO empty and sram_we=0.
//          On idle: flush_done=1 for one cycle, then RUN.
//   flush while already in FLUSH: ignored.
//  wr_ready = (state==RUN) && !(hold_valid && fifo_full).
//  Accepted write, three cases:
//   hold invalid            -> load hold with the write; mask taken as-is.
//   hold valid, same addr   -> merge into hold:
//                               mask = old_mask | wr_mask;
//                               lanes with wr_mask=1 take the new colour and depth;
//                               other lanes are unchanged.
//   hold valid, other addr  -> push hold into the FIFO; load hold with the write.
//   wr_mask==0              -> accepted, no state change, timer not reset.
//  Timer: cleared on every accepted write; otherwise increments while hold is valid.
//   At HOLD_TIMEOUT, hold is pushed to the FIFO if not full; else it waits.
//  Drain: if FIFO non-empty && sram_gnt, pop the head.
//   The next edge registers sram_* with the popped entry and sets sram_we=1 for 1 cycle.
//   Otherwise sram_we=0 and sram_addr/color/depth/mask hold their last values.
//   Latency is 1 cycle from pop to sram_we.
//  Simultaneous push+pop in the same cycle is legal; count is unchanged.
//  No FIFO bypass: an entry pushed at edge N can pop at N+1 at the earliest.
//  FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//   Count is log2(FIFO_DEPTH)+1 bits.
//  Entry order is strict FIFO, so SRAM sees writes in eviction order.
//  rd_hazard=1 if rd_addr matches any of:
//   hold (when valid); any valid FIFO entry; sram_addr while sram_we=1.
//  The rasterizer must stall its depth read while rd_hazard=1.
//  Data widths are pass-through; there is no arithmetic except the counters.
// TESTING
//  Writes A=0x0010 mask 0x00FF, then A mask 0xFF00, then B=0x0011
//   -> one SRAM write to 0x0010, mask 0xFFFF, each lane carrying its last-written data.
//  Same-addr overlap: mask 0x000F lanes=0x111111, then 0x0003 lanes=0x222222
//   -> lanes 0-1 =0x222222, lanes 2-3 =0x111111, mask 0x000F.
//  sram_gnt=0, FIFO_DEPTH=4, write 6 distinct addresses
//   -> wr_ready drops after write 5; raise sram_gnt -> 5 in-order writes.
//  Single write, no further traffic
//   -> evicted after 8 idle cycles; sram_we pulses once.
//  rd_addr equal to a queued entry -> rd_hazard=1 until the cycle after its sram_we.
//  flush with 3 entries pending -> wr_ready=0 until flush_done.
//   flush_done pulses exactly once, after the last sram_we.
//  Reset asserted mid-drain -> sram_we=0 immediately; no further writes; wr_ready=1 after release.

Source files
------------

// File: rtl/cd_sram_write_coalescer.sv
// cd_sram_write_coalescer
// Write coalescer between the rasterizer Color/Depth write port and the
// Color/Depth SRAM. Consecutive masked writes to the same SRAM word are merged
// in a holding register. Evicted words queue in a small FIFO that drains
// whenever the SRAM grants a write slot. A combinational hazard flag tells the
// rasterizer when a depth read would see a stale SRAM word.

module cd_sram_write_coalescer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [15:0]  wr_addr,
  input  logic [383:0] wr_color,
  input  logic [335:0] wr_depth,
  input  logic [15:0]  wr_mask,
  input  logic [15:0]  rd_addr,
  output logic         rd_hazard,
  input  logic         sram_gnt,
  output logic         sram_we,
  output logic [15:0]  sram_addr,
  output logic [383:0] sram_color,
  output logic [335:0] sram_depth,
  output logic [15:0]  sram_mask,
  input  logic         flush,
  output logic         flush_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]   state;

  // Holding register: the word currently being coalesced
  logic         hold_valid;
  logic [15:0]  hold_addr;
  logic [383:0] hold_color;
  logic [335:0] hold_depth;
  logic [15:0]  hold_mask;
  logic [TW-1:0] timer;

  // Eviction FIFO storage and bookkeeping
  logic [15:0]  fifo_addr  [FIFO_DEPTH];
  logic [383:0] fifo_color [FIFO_DEPTH];
  logic [335:0] fifo_depth [FIFO_DEPTH];
  logic [15:0]  fifo_mask  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic         fifo_full;
  logic         fifo_empty;
  logic         wr_fire;
  logic         wr_take;
  logic         same_addr;
  logic         timeout_hit;
  logic         push_conflict;
  logic         push_evict;
  logic         push;
  logic         pop;
  logic         idle;
  logic [383:0] merged_color;
  logic [335:0] merged_depth;
  logic [PW-1:0] slot_off;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // A new word can only be taken when there is somewhere to put the old one
  assign wr_ready = (state == ST_RUN) && !(hold_valid && fifo_full);
  assign wr_fire  = wr_valid && wr_ready;
  // An all-zero mask is consumed but must not disturb the hold or its timer
  assign wr_take  = wr_fire && (wr_mask != '0);

  assign same_addr     = hold_valid && (hold_addr == wr_addr);
  assign timeout_hit   = hold_valid && (timer >= TW'(HOLD_TIMEOUT));
  assign push_conflict = wr_take && hold_valid && !same_addr;
  assign push_evict    = !wr_take && hold_valid && !fifo_full &&
                         ((state == ST_FLUSH) || timeout_hit);
  assign push          = push_conflict || push_evict;
  assign pop           = !fifo_empty && sram_gnt;
  assign idle          = !hold_valid && fifo_empty && !sram_we;

  // Lane-wise merge: lanes selected by the new mask take the new data
  always_comb begin
    merged_color = hold_color;
    merged_depth = hold_depth;
    for (int i = 0; i < 16; i++) begin
      if (wr_mask[i]) begin
        merged_color[24*i +: 24] = wr_color[24*i +: 24];
        merged_depth[21*i +: 21] = wr_depth[21*i +: 21];
      end
    end
  end

  // Hazard if the read address is still anywhere between rasterizer and SRAM
  always_comb begin
    rd_hazard = 1'b0;
    slot_off  = '0;
    if (hold_valid && (hold_addr == rd_addr)) begin
      rd_hazard = 1'b1;
    end
    if (sram_we && (sram_addr == rd_addr)) begin
      rd_hazard = 1'b1;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr;
      if (({1'b0, slot_off} < count) && (fifo_addr[i] == rd_addr)) begin
        rd_hazard = 1'b1;
      end
    end
  end

  // Holding register load, merge and eviction
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_color <= '0;
      hold_depth <= '0;
      hold_mask  <= '0;
    end else if (wr_take) begin
      hold_valid <= 1'b1;
      hold_addr  <= wr_addr;
      if (same_addr) begin
        hold_color <= merged_color;
        hold_depth <= merged_depth;
        hold_mask  <= hold_mask | wr_mask;
      end else begin
        hold_color <= wr_color;
        hold_depth <= wr_depth;
        hold_mask  <= wr_mask;
      end
    end else if (push_evict) begin
      hold_valid <= 1'b0;
    end
  end

  // Idle timer: restarts on real writes, saturates at the timeout
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      timer <= '0;
    end else if (wr_take || push_evict || !hold_valid) begin
      timer <= '0;
    end else if (timer < TW'(HOLD_TIMEOUT)) begin
      timer <= timer + TW'(1);
    end
  end

  // FIFO storage; contents need no reset because count guards validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= hold_addr;
      fifo_color[wr_ptr] <= hold_color;
      fifo_depth[wr_ptr] <= hold_depth;
      fifo_mask[wr_ptr]  <= hold_mask;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // SRAM write port: registered head of FIFO, data held between strobes
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_color <= '0;
      sram_depth <= '0;
      sram_mask  <= '0;
    end else begin
      sram_we <= pop;
      if (pop) begin
        sram_addr  <= fifo_addr[rd_ptr];
        sram_color <= fifo_color[rd_ptr];
        sram_depth <= fifo_depth[rd_ptr];
        sram_mask  <= fifo_mask[rd_ptr];
      end
    end
  end

  // Run/flush control; flush_done is a single-cycle pulse on the way back to RUN
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (flush) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (idle) begin
            flush_done <= 1'b1;
            state      <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
